// File: rtl/seqdiv_pkg.sv
// Shared types, constants and helpers for the sequential 16-bit divider.
// Optional feature macro: SEQDIV_EARLY_TERM_EN (early termination on short dividends).
package seqdiv_pkg;

    localparam int N     = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    // Leading-zero count of a 16-bit value; a zero input yields 16.
    function automatic logic [CNT_W-1:0] lzc16(input logic [N-1:0] v);
        logic [CNT_W-1:0] cnt;
        logic             found;
        cnt   = CNT_W'(N);
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                cnt   = CNT_W'(N - 1 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/seq_divider16_cla.sv
// Parameterised carry generate/propagate adder/subtractor used for the
// divider's trial subtraction (sub=1 computes a - b).
module claAddSubGen #(
    parameter int M = 17
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         sub,
    output logic [M-1:0] out
);

    logic [M-1:0] b_eff;
    logic [M-1:0] g;
    logic [M-1:0] p;
    logic [M-1:0] c;

    assign b_eff = b ^ {M{sub}};
    assign c[0]  = sub;

    // Per-bit generate/propagate terms, carry into the next bit and sum.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_bit
            assign g[gi]   = a[gi] & b_eff[gi];
            assign p[gi]   = a[gi] ^ b_eff[gi];
            assign out[gi] = p[gi] ^ c[gi];
            if (gi < M - 1) begin : g_carry
                assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/seq_divider16.sv
// Iterative radix-2 restoring divider, 16-bit signed/unsigned, one quotient
// bit per cycle. Truncating quotient, remainder takes the dividend's sign.
// Optional feature macro: SEQDIV_EARLY_TERM_EN skips leading zero bits of
// the dividend magnitude so only its significant bits are iterated.
module seq_divider16
    import seqdiv_pkg::*;
(
    input  logic         clk,
    input  logic         rstN,
    input  logic         start,
    input  logic         signedFlag,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         divByZero
);

    state_t           state_reg, state_next;
    // dq holds the dividend magnitude and is progressively replaced by quotient bits
    logic [N-1:0]     dq_reg, dq_next;
    logic [N-1:0]     dmag_reg, dmag_next;
    // Partial remainder is always below the divisor, so 16 bits hold it;
    // the 17th bit only exists in the shifted trial operand.
    logic [N-1:0]     pr_reg, pr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             qneg_reg, qneg_next;
    logic             rneg_reg, rneg_next;
    logic             dz_reg, dz_next;
    logic [N-1:0]     quotient_reg, quotient_next;
    logic [N-1:0]     remainder_reg, remainder_next;
    logic             done_reg, done_next;
    logic             dbz_reg, dbz_next;

    logic [N:0]       trial_a;
    logic [N:0]       trial_b;
    logic [N:0]       trial_diff;
    logic [N-1:0]     dvd_mag;
    logic [N-1:0]     dvs_mag;
    logic [CNT_W-1:0] iter_n;
    logic [N-1:0]     dq_init;

    assign trial_a = {pr_reg, dq_reg[N-1]};
    assign trial_b = {1'b0, dmag_reg};

    claAddSubGen #(.M(N + 1)) u_trial_sub (
        .a   (trial_a),
        .b   (trial_b),
        .sub (1'b1),
        .out (trial_diff)
    );

    // Next-state and datapath update for IDLE/ITER/FIX.
    always_comb begin
        state_next     = state_reg;
        dq_next        = dq_reg;
        dmag_next      = dmag_reg;
        pr_next        = pr_reg;
        cnt_next       = cnt_reg;
        qneg_next      = qneg_reg;
        rneg_next      = rneg_reg;
        dz_next        = dz_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        done_next      = 1'b0;

        dvd_mag = (signedFlag && dividend[N-1]) ? (~dividend + N'(1)) : dividend;
        dvs_mag = (signedFlag && divisor[N-1])  ? (~divisor + N'(1))  : divisor;
`ifdef SEQDIV_EARLY_TERM_EN
        iter_n  = CNT_W'(N) - lzc16(dvd_mag);
        dq_init = dvd_mag << lzc16(dvd_mag);
`else
        iter_n  = CNT_W'(N);
        dq_init = dvd_mag;
`endif

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    qneg_next = signedFlag & (dividend[N-1] ^ divisor[N-1]);
                    rneg_next = signedFlag & dividend[N-1];
                    pr_next   = '0;
                    dmag_next = dvs_mag;
                    cnt_next  = iter_n;
                    dz_next   = (divisor == '0);
                    if (divisor == '0) begin
                        // Raw dividend bits are what a zero divide returns as remainder
                        dq_next    = dividend;
                        state_next = FIX;
                    end else begin
                        dq_next    = dq_init;
                        state_next = (iter_n == '0) ? FIX : ITER;
                    end
                end
            end
            ITER: begin
                if (!trial_diff[N]) begin
                    pr_next = trial_diff[N-1:0];
                    dq_next = {dq_reg[N-2:0], 1'b1};
                end else begin
                    pr_next = trial_a[N-1:0];
                    dq_next = {dq_reg[N-2:0], 1'b0};
                end
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                if (dz_reg) begin
                    quotient_next  = '1;
                    remainder_next = dq_reg;
                end else begin
                    quotient_next  = qneg_reg ? (~dq_reg + N'(1)) : dq_reg;
                    remainder_next = rneg_reg ? (~pr_reg + N'(1)) : pr_reg;
                end
                dbz_next   = dz_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dq_reg        <= '0;
            dmag_reg      <= '0;
            pr_reg        <= '0;
            cnt_reg       <= '0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            dq_reg        <= dq_next;
            dmag_reg      <= dmag_next;
            pr_reg        <= pr_next;
            cnt_reg       <= cnt_next;
            qneg_reg      <= qneg_next;
            rneg_reg      <= rneg_next;
            dz_reg        <= dz_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            done_reg      <= done_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign divByZero = dbz_reg;

endmodule
